ex_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the EX stage.
//  - Executes MULT/MULTU/DIV/DIVU and owns the HI/LO architectural registers.
//  - Raises a stall request so the pipeline holds EX until the result is ready.
//  - Adds what the single-cycle ALU path lacks: iterative/pipelined arithmetic,
//    a busy handshake, flush cancel and divide-by-zero reporting.

---
 rtl/ex_muldiv_unit_pkg.sv | 28 ++
 rtl/ex_muldiv_unit_if.sv | 29 ++
 rtl/ex_muldiv_unit_div_iter.sv | 65 ++++++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam int unsigned MD_OP_W = 2;

  typedef enum logic [MD_OP_W-1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_MUL  = 2'b01,
    MD_ST_DIV  = 2'b10,
    MD_ST_DONE = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import ex_muldiv_unit_pkg::*;

  logic               flush;
  logic               start;
  logic [MD_OP_W-1:0] op;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               stallreq;
  logic               busy;
  logic               result_valid;
  logic               div_by_zero;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;

  modport master (
    output flush, start, op, src_a, src_b,
    input  stallreq, busy, result_valid, div_by_zero, hi_o, lo_o
  );

  modport slave (
    input  flush, start, op, src_a, src_b,
    output stallreq, busy, result_valid, div_by_zero, hi_o, lo_o
  );

endinterface

// File: rtl/ex_muldiv_unit_div_iter.sv
// Restoring unsigned divider core: one quotient bit per cycle, first bit on the load edge.
module ex_muldiv_unit_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] cur_rem;
  logic [WIDTH-1:0] cur_quo;
  logic [WIDTH-1:0] cur_b;
  logic [WIDTH-1:0] nxt_rem;
  logic [WIDTH-1:0] nxt_quo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [CNT_W-1:0] cnt_q;
  logic             advance;

  // One restoring step; a borrow out of the trial subtract means keep the shifted remainder.
  always_comb begin
    cur_rem = load ? '0 : rem;
    cur_quo = load ? a  : quot;
    cur_b   = load ? b  : b_q;
    shifted = {cur_rem, cur_quo[WIDTH-1]};
    diff    = shifted - {1'b0, cur_b};
    if (diff[WIDTH]) begin
      nxt_rem = shifted[WIDTH-1:0];
      nxt_quo = {cur_quo[WIDTH-2:0], 1'b0};
    end else begin
      nxt_rem = diff[WIDTH-1:0];
      nxt_quo = {cur_quo[WIDTH-2:0], 1'b1};
    end
    advance = load | (cnt_q != CNT_W'(WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quot  <= '0;
      b_q   <= '0;
      cnt_q <= CNT_W'(WIDTH);
      done  <= 1'b0;
    end else if (advance) begin
      rem  <= nxt_rem;
      quot <= nxt_quo;
      if (load) begin
        b_q   <= b;
        cnt_q <= CNT_W'(1);
        done  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        done  <= (cnt_q + CNT_W'(1)) == CNT_W'(WIDTH);
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls EX until the result lands.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave md
);
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned MCNT_W = $clog2(MUL_STAGES + 1);

  md_state_e         state;
  logic [MCNT_W-1:0] mul_cnt;
  logic              neg_q;
  logic              rem_neg_q;
  logic              b_zero_q;
  logic [PROD_W-1:0] mul_chain [MUL_STAGES];
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic              result_valid_q;
  logic              div_by_zero_q;

  md_op_e            op_in;
  logic              in_signed;
  logic              sign_a;
  logic              sign_b;
  logic              accept;
  logic              div_load;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [WIDTH-1:0]  div_quot;
  logic [WIDTH-1:0]  div_rem;
  logic [WIDTH-1:0]  quot_fix;
  logic [WIDTH-1:0]  rem_fix;
  logic [PROD_W-1:0] prod_mag;
  logic [PROD_W-1:0] prod_fix;
  logic              div_done;

  // Operand magnitudes at issue, sign fix-up applied when HI/LO are written.
  always_comb begin
    op_in     = md_op_e'(md.op);
    in_signed = md_is_signed(op_in);
    sign_a    = in_signed & md.src_a[WIDTH-1];
    sign_b    = in_signed & md.src_b[WIDTH-1];
    abs_a     = sign_a ? -md.src_a : md.src_a;
    abs_b     = sign_b ? -md.src_b : md.src_b;
    accept    = (state == MD_ST_IDLE) & md.start & ~md.flush;
    div_load  = accept & md_is_div(op_in);
    prod_mag  = PROD_W'(abs_a) * PROD_W'(abs_b);
    prod_fix  = neg_q ? -mul_chain[MUL_STAGES-1] : mul_chain[MUL_STAGES-1];
    quot_fix  = neg_q ? -div_quot : div_quot;
    rem_fix   = rem_neg_q ? -div_rem : div_rem;
  end

  ex_muldiv_unit_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .a    (abs_a),
    .b    (abs_b),
    .done (div_done),
    .quot (div_quot),
    .rem  (div_rem)
  );

  // Product pipeline: stage 0 captures at issue, last stage is ready when MUL finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MUL_STAGES); i++) mul_chain[i] <= '0;
    end else begin
      if (accept) mul_chain[0] <= prod_mag;
      for (int i = 1; i < int'(MUL_STAGES); i++) mul_chain[i] <= mul_chain[i-1];
    end
  end

  // Control FSM; flush wins over everything and drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= MD_ST_IDLE;
      mul_cnt        <= '0;
      neg_q          <= 1'b0;
      rem_neg_q      <= 1'b0;
      b_zero_q       <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      if (md.flush) begin
        state <= MD_ST_IDLE;
      end else begin
        unique case (state)
          MD_ST_IDLE: begin
            if (md.start) begin
              neg_q     <= sign_a ^ sign_b;
              rem_neg_q <= sign_a;
              b_zero_q  <= (md.src_b == '0);
              mul_cnt   <= MCNT_W'(1);
              state     <= md_is_div(op_in) ? MD_ST_DIV : MD_ST_MUL;
            end
          end
          MD_ST_MUL: begin
            if (mul_cnt == MCNT_W'(MUL_STAGES)) begin
              hi_q           <= prod_fix[PROD_W-1:WIDTH];
              lo_q           <= prod_fix[WIDTH-1:0];
              result_valid_q <= 1'b1;
              state          <= MD_ST_DONE;
            end else begin
              mul_cnt <= mul_cnt + MCNT_W'(1);
            end
          end
          MD_ST_DIV: begin
            if (div_done) begin
              hi_q           <= rem_fix;
              lo_q           <= quot_fix;
              result_valid_q <= 1'b1;
              div_by_zero_q  <= b_zero_q;
              state          <= MD_ST_DONE;
            end
          end
          MD_ST_DONE: state <= MD_ST_IDLE;
          default:    state <= MD_ST_IDLE;
        endcase
      end
    end
  end

  assign md.stallreq     = accept | (state == MD_ST_MUL) | (state == MD_ST_DIV);
  assign md.busy         = (state != MD_ST_IDLE);
  assign md.result_valid = result_valid_q;
  assign md.div_by_zero  = div_by_zero_q;
  assign md.hi_o         = hi_q;
  assign md.lo_o         = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned MUL_STAGES = 2;

  logic clk = 1'b0;
  logic rst;

  ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  ex_muldiv_unit #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Architectural result from plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      x, y, q, r;
    logic [63:0] p;
    dbz = 1'b0;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(x * y); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin
          dbz = 1'b1; hi = a; lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          q = x / y; r = x % y; lo = 32'(q); hi = 32'(r);
        end
      end
      default: begin
        if (b == 0) begin dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op for one cycle (optionally keep start up with a different op while busy).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] mh, ml;
    logic        mdbz;
    int          lat, cyc;
    bit          hold_ok, seen;
    model(op, a, b, mh, ml, mdbz);
    lat = op[1] ? int'(WIDTH) + 1 : int'(MUL_STAGES) + 1;
    @(negedge clk);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    #1 check("stall_at_issue", bus.stallreq, 1);
    @(posedge clk); #1;
    if (poke) begin
      bus.op = op ^ 2'b10; bus.src_a = $urandom; bus.src_b = $urandom;
    end else begin
      bus.start = 1'b0;
    end
    cyc = 0; hold_ok = 1'b1; seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) bus.start = 1'b0;
      if (bus.result_valid) seen = 1'b1;
      else if (!bus.stallreq || !bus.busy || bus.div_by_zero) hold_ok = 1'b0;
    end
    if (!seen) begin
      check("result_timeout", 0, 1);
    end else begin
      check("latency", 64'(cyc), 64'(lat));
      check("stall_hold", hold_ok, 1);
      check("stall_done", bus.stallreq, 0);
      check("hi", bus.hi_o, mh);
      check("lo", bus.lo_o, ml);
      check("div_by_zero", bus.div_by_zero, mdbz);
      exp_hi = mh; exp_lo = ml;
    end
  endtask

  initial begin
    bit quiet;
    bus.flush = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hi", bus.hi_o, 0);
    check("rst_lo", bus.lo_o, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_stall", bus.stallreq, 0);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b01, 32'd12345, 32'd678, 1'b1);
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // Flush mid-divide: back to idle next edge, no result, HI/LO untouched.
    @(negedge clk);
    bus.op = 2'b11; bus.src_a = 32'd77; bus.src_b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_stall", bus.stallreq, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) quiet = 1'b0;
    end
    check("flush_quiet", quiet, 1);
    check("flush_hi", bus.hi_o, exp_hi);
    check("flush_lo", bus.lo_o, exp_lo);

    // Flush and start together in idle: start ignored.
    @(negedge clk);
    bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    #1 check("flush_start_stall", bus.stallreq, 0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", bus.busy, 0);

    for (int i = 0; i < 30; i++) run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a divide.
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    @(negedge clk);
    bus.op = 2'b10; bus.src_a = 32'd500; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", bus.hi_o, 0);
    check("arst_lo", bus.lo_o, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_stall", bus.stallreq, 0);
    check("arst_valid", bus.result_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_op(2'b11, 32'd100, 32'd7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
